// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
// Decodes a two-frame register protocol carried on the SPI slave byte engine
// into a 16 x 8-bit register bank. It also drives the slave's tx_data so that
// read data is shifted out on the next CS frame.
//
// Ports:
//   clk_in    - system clock
//   rst       - asynchronous active-low reset
//   spi_cs    - raw SPI chip select (asynchronous, synchronized here)
//   rx_data   - byte received by the SPI slave
//   rx_flag   - high when the slave received a full 8 bits in the frame
//   tx_data   - byte the slave loads at the next CS fall
//   reg_wr    - one-cycle write strobe
//   reg_addr  - write address, valid with reg_wr
//   reg_wdata - write data, valid with reg_wr
//   regs_flat - register bank, register n at bits [8n+7:8n]
//   err_cnt   - saturating protocol error counter
//   busy      - high while a transaction is open (state != IDLE)
//
// Command byte: bit7 = read(1)/write(0), bits6:4 must be 000, bits3:0 = address.
// Registers 0 (DEV_ID) and 1 (status) are read-only.

module spi_reg_bridge #(
  parameter logic [7:0]  DEV_ID     = 8'hA5,
  parameter int          SAMPLE_DLY = 3,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         spi_cs,
  input  logic [7:0]   rx_data,
  input  logic         rx_flag,
  output logic [7:0]   tx_data,
  output logic         reg_wr,
  output logic [3:0]   reg_addr,
  output logic [7:0]   reg_wdata,
  output logic [127:0] regs_flat,
  output logic [7:0]   err_cnt,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_READ = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        cs_s1;
  logic        cs_s2;
  logic        cs_d;
  logic        cs_rise;

  logic [7:0]  cap_cnt;
  logic        capture;
  logic        frame_drop;
  logic        byte_ok;
  logic        byte_short;

  logic [15:0] to_cnt;
  logic        timeout;

  logic [3:0]  addr_q;
  logic [7:0]  bank [0:15];
  logic [7:0]  status_val;
  logic [7:0]  read_val;

  logic        latch_addr;
  logic        load_read;
  logic        clear_tx;
  logic        do_write;
  logic        fsm_err;
  logic        err_inc;

  // Two-flop synchronizer plus edge register for the chip select. The flops
  // reset high (CS idle) so that leaving reset never looks like a CS rise.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cs_s1 <= 1'b1;
      cs_s2 <= 1'b1;
      cs_d  <= 1'b1;
    end else begin
      cs_s1 <= spi_cs;
      cs_s2 <= cs_s1;
      cs_d  <= cs_s2;
    end
  end

  assign cs_rise = cs_s2 & ~cs_d;

  // Capture delay counter: loaded on every CS rise, counts down to zero.
  // A count of zero means idle; the capture fires while the count is 1.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cap_cnt <= '0;
    end else if (cs_rise) begin
      cap_cnt <= 8'(SAMPLE_DLY);
    end else if (cap_cnt != 8'd0) begin
      cap_cnt <= cap_cnt - 8'd1;
    end
  end

  // A CS rise that lands while a capture is still pending restarts the
  // counter, so the pending frame is dropped and counted as an error.
  assign frame_drop = cs_rise && (cap_cnt != 8'd0);
  assign capture    = (cap_cnt == 8'd1) && !cs_rise;
  assign byte_ok    = capture && rx_flag;
  assign byte_short = capture && !rx_flag;

  // Inter-frame timeout counter, cleared in IDLE and on every good byte.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || byte_ok) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout = (state != IDLE) && (to_cnt == (TIMEOUT - 16'd1));
  assign busy    = (state != IDLE);

  // Read mux: register 1 is a live status value, register 0 is constant.
  assign status_val = {busy, 3'b000, err_cnt[3:0]};

  always_comb begin
    read_val = bank[rx_data[3:0]];
    case (rx_data[3:0])
      4'd0:    read_val = DEV_ID;
      4'd1:    read_val = status_val;
      default: read_val = bank[rx_data[3:0]];
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. Captures are tested before the timeout,
  // so a capture that coincides with the timeout wins.
  always_comb begin
    state_next = state;
    latch_addr = 1'b0;
    load_read  = 1'b0;
    clear_tx   = 1'b0;
    do_write   = 1'b0;
    fsm_err    = 1'b0;
    case (state)
      IDLE: begin
        if (byte_ok) begin
          if (rx_data[6:4] != 3'b000) begin
            fsm_err = 1'b1;
          end else if (rx_data[7]) begin
            load_read  = 1'b1;
            state_next = WAIT_READ;
          end else begin
            latch_addr = 1'b1;
            state_next = WAIT_DATA;
          end
        end else if (byte_short) begin
          fsm_err = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (byte_ok) begin
          if (addr_q < 4'd2) begin
            fsm_err = 1'b1;
          end else begin
            do_write = 1'b1;
          end
          state_next = IDLE;
        end else if (byte_short) begin
          fsm_err    = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          fsm_err    = 1'b1;
          clear_tx   = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_READ: begin
        // The read data has already gone out; a short frame still clears
        // tx_data so stale read data is not replayed on a later frame.
        if (byte_ok) begin
          clear_tx   = 1'b1;
          state_next = IDLE;
        end else if (byte_short) begin
          fsm_err    = 1'b1;
          clear_tx   = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          fsm_err    = 1'b1;
          clear_tx   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign err_inc = fsm_err || frame_drop;

  // Datapath: address latch, write strobe, register bank, tx_data, errors.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_data   <= '0;
      err_cnt   <= '0;
      for (int i = 0; i < 16; i++) begin
        bank[i] <= '0;
      end
    end else begin
      reg_wr <= do_write;
      if (latch_addr) begin
        addr_q <= rx_data[3:0];
      end
      if (do_write) begin
        reg_addr     <= addr_q;
        reg_wdata    <= rx_data;
        bank[addr_q] <= rx_data;
      end
      if (load_read) begin
        tx_data <= read_val;
      end else if (clear_tx) begin
        tx_data <= 8'h00;
      end
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Flattened view of the bank with the two read-only registers overlaid.
  always_comb begin
    regs_flat = '0;
    for (int n = 2; n < 16; n++) begin
      regs_flat[8*n +: 8] = bank[n];
    end
    regs_flat[7:0]  = DEV_ID;
    regs_flat[15:8] = status_val;
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge
// Directed bench for spi_reg_bridge. Frames are modelled by dropping CS,
// presenting rx_data/rx_flag as the SPI slave would, then raising CS and
// waiting long enough for the synchronizer and capture delay to complete.
// Write strobes are counted by a monitor so single pulses can be checked.

module tb_spi_reg_bridge;

  logic         clk_in;
  logic         rst;
  logic         spi_cs;
  logic [7:0]   rx_data;
  logic         rx_flag;
  logic [7:0]   tx_data;
  logic         reg_wr;
  logic [3:0]   reg_addr;
  logic [7:0]   reg_wdata;
  logic [127:0] regs_flat;
  logic [7:0]   err_cnt;
  logic         busy;

  int           checks;
  int           errors;
  int           wr_count;
  logic [3:0]   last_addr;
  logic [7:0]   last_data;

  spi_reg_bridge #(
    .DEV_ID     (8'hA5),
    .SAMPLE_DLY (3),
    .TIMEOUT    (16'd200)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .spi_cs    (spi_cs),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .tx_data   (tx_data),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .regs_flat (regs_flat),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  // 100 MHz clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Counts write strobes on the falling edge, away from the active edge.
  initial begin
    wr_count  = 0;
    last_addr = '0;
    last_data = '0;
    forever begin
      @(negedge clk_in);
      if (reg_wr === 1'b1) begin
        wr_count  = wr_count + 1;
        last_addr = reg_addr;
        last_data = reg_wdata;
      end
    end
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One SPI frame: CS low, byte presented, CS high, then enough cycles for
  // the 2-flop sync, edge detect and capture delay to finish.
  task automatic applyStimulus(input logic [7:0] data, input logic flag);
    @(posedge clk_in);
    #1;
    spi_cs = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    rx_data = data;
    rx_flag = flag;
    spi_cs  = 1'b1;
    repeat (10) @(posedge clk_in);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    spi_cs  = 1'b1;
    rx_data = 8'h00;
    rx_flag = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    // Reset state.
    checkOutput("rst_tx", 32'(tx_data), 32'h00);
    checkOutput("rst_err", 32'(err_cnt), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_wr", 32'(reg_wr), 32'h0);
    checkOutput("rst_reg0", 32'(regs_flat[7:0]), 32'hA5);
    checkOutput("rst_reg1", 32'(regs_flat[15:8]), 32'h00);
    checkOutput("rst_upper_zero", 32'(regs_flat[127:16] == '0), 32'h1);

    // Read register 0.
    applyStimulus(8'h80, 1'b1);
    checkOutput("rd0_tx", 32'(tx_data), 32'hA5);
    checkOutput("rd0_busy", 32'(busy), 32'h1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("rd0_tx_clear", 32'(tx_data), 32'h00);
    checkOutput("rd0_idle", 32'(busy), 32'h0);

    // Write 0x3C to register 5, then read it back.
    applyStimulus(8'h05, 1'b1);
    checkOutput("wr5_busy", 32'(busy), 32'h1);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("wr5_count", 32'(wr_count), 32'd1);
    checkOutput("wr5_addr", 32'(last_addr), 32'h5);
    checkOutput("wr5_data", 32'(last_data), 32'h3C);
    checkOutput("wr5_bank", 32'(regs_flat[47:40]), 32'h3C);
    checkOutput("wr5_idle", 32'(busy), 32'h0);
    applyStimulus(8'h85, 1'b1);
    checkOutput("rd5_tx", 32'(tx_data), 32'h3C);
    applyStimulus(8'h00, 1'b1);
    checkOutput("rd5_tx_clear", 32'(tx_data), 32'h00);

    // Write command to 7 with no data frame: timeout.
    applyStimulus(8'h07, 1'b1);
    checkOutput("to_busy", 32'(busy), 32'h1);
    repeat (250) @(posedge clk_in);
    #1;
    checkOutput("to_idle", 32'(busy), 32'h0);
    checkOutput("to_err", 32'(err_cnt), 32'h01);
    checkOutput("to_nowr", 32'(wr_count), 32'd1);
    checkOutput("to_tx", 32'(tx_data), 32'h00);
    applyStimulus(8'h07, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    checkOutput("wr7_count", 32'(wr_count), 32'd2);
    checkOutput("wr7_bank", 32'(regs_flat[63:56]), 32'h5A);
    checkOutput("wr7_err", 32'(err_cnt), 32'h01);

    // Short frame while waiting for data, then an invalid command.
    applyStimulus(8'h07, 1'b1);
    applyStimulus(8'hEE, 1'b0);
    checkOutput("short_err", 32'(err_cnt), 32'h02);
    checkOutput("short_idle", 32'(busy), 32'h0);
    checkOutput("short_bank", 32'(regs_flat[63:56]), 32'h5A);
    checkOutput("short_nowr", 32'(wr_count), 32'd2);
    applyStimulus(8'h15, 1'b1);
    checkOutput("badcmd_err", 32'(err_cnt), 32'h03);
    checkOutput("badcmd_idle", 32'(busy), 32'h0);

    // Write to read-only register 0, then read status register 1.
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("ro_nowr", 32'(wr_count), 32'd2);
    checkOutput("ro_reg0", 32'(regs_flat[7:0]), 32'hA5);
    checkOutput("ro_err", 32'(err_cnt), 32'h04);
    applyStimulus(8'h81, 1'b1);
    checkOutput("rd1_tx", 32'(tx_data), 32'h04);
    applyStimulus(8'h00, 1'b1);
    checkOutput("rd1_tx_clear", 32'(tx_data), 32'h00);

    // Asynchronous reset in the middle of a write.
    applyStimulus(8'h09, 1'b1);
    checkOutput("arst_pre_busy", 32'(busy), 32'h1);
    @(posedge clk_in);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_err", 32'(err_cnt), 32'h00);
    checkOutput("arst_tx", 32'(tx_data), 32'h00);
    checkOutput("arst_addr", 32'(reg_addr), 32'h0);
    checkOutput("arst_wdata", 32'(reg_wdata), 32'h00);
    checkOutput("arst_bank7", 32'(regs_flat[63:56]), 32'h00);
    @(posedge clk_in);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    applyStimulus(8'h0A, 1'b1);
    checkOutput("post_cmd_busy", 32'(busy), 32'h1);
    checkOutput("post_cmd_nowr", 32'(wr_count), 32'd2);
    applyStimulus(8'h77, 1'b1);
    checkOutput("post_wr_count", 32'(wr_count), 32'd3);
    checkOutput("post_wr_bank", 32'(regs_flat[87:80]), 32'h77);
    checkOutput("post_err", 32'(err_cnt), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
